// File: rtl/dtc_eval_driver.sv
// Valid/ready evaluation front-end for the dtc_* classifiers: registers a feature vector onto the
// classifier bus, captures the decision, emits a result stream. Stats built under DTC_DRV_STATS_EN.
module dtc_eval_driver #(
  parameter int unsigned FEAT_W = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_feat,
  input  logic              s_label,
  output logic [FEAT_W-1:0] cls_inp,
  input  logic              cls_outp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_pred,
  output logic              m_match,
  input  logic              clear,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  correct_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  state_t            state_q, state_d;
  logic [FEAT_W-1:0] cls_inp_q, cls_inp_d;
  logic              label_q, label_d;
  logic              m_valid_q, m_valid_d;
  logic              m_pred_q, m_pred_d;
  logic              m_match_q, m_match_d;
  logic              accept;
  logic              eval_fire;
  logic              cur_match;

  assign s_ready   = (state_q == IDLE) | ((state_q == OUT) & m_ready);
  assign accept    = s_valid & s_ready;
  assign eval_fire = (state_q == EVAL);
  assign cur_match = (cls_outp == label_q);

  always_comb begin
    state_d   = state_q;
    cls_inp_d = cls_inp_q;
    label_d   = label_q;
    m_valid_d = m_valid_q;
    m_pred_d  = m_pred_q;
    m_match_d = m_match_q;
    case (state_q)
      IDLE: if (accept) state_d = EVAL;
      EVAL: begin
        m_pred_d  = cls_outp;
        m_match_d = cur_match;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        state_d   = accept ? EVAL : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cls_inp_d = s_feat;
      label_d   = s_label;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cls_inp_q <= '0;
      label_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_pred_q  <= 1'b0;
      m_match_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_inp_q <= cls_inp_d;
      label_q   <= label_d;
      m_valid_q <= m_valid_d;
      m_pred_q  <= m_pred_d;
      m_match_q <= m_match_d;
    end
  end

  assign cls_inp = cls_inp_q;
  assign m_valid = m_valid_q;
  assign m_pred  = m_pred_q;
  assign m_match = m_match_q;

`ifdef DTC_DRV_STATS_EN
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] correct_q, correct_d;

  // clear has priority over a coincident EVAL increment; both counters saturate independently
  always_comb begin
    total_d   = total_q;
    correct_d = correct_q;
    if (clear) begin
      total_d   = '0;
      correct_d = '0;
    end else if (eval_fire) begin
      if (total_q != '1) total_d = total_q + CNT_W'(1);
      if (cur_match && (correct_q != '1)) correct_d = correct_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      correct_q <= '0;
    end else begin
      total_q   <= total_d;
      correct_q <= correct_d;
    end
  end

  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;
`else
  logic unused_stats;
  assign unused_stats = clear ^ eval_fire;
  assign total_cnt    = '0;
  assign correct_cnt  = '0;
`endif

endmodule
